// File: rtl/uart_rx_frame_receiver_if.sv
// uart_rx_frame_receiver_if: serial line, frame configuration and received-word outputs of the UART receiver
interface uart_rx_frame_receiver_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Par_Err;
    logic                  Stp_Err;
    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, Data_Valid, Par_Err, Stp_Err
    );
    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, Data_Valid, Par_Err, Stp_Err
    );
endinterface

// File: rtl/uart_rx_frame_receiver.sv
// uart_rx_frame_receiver: oversampled UART receiver with 3-sample majority vote, parity and stop checks
module uart_rx_frame_receiver #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESCALE_W  = 6,
    parameter int SYNC_STAGES = 2
) (
    input logic CLK,
    input logic RST,
    uart_rx_frame_receiver_if.slave bus
);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [PRESCALE_W-1:0] edge_q, edge_d, ps_q, ps_d, half;
    logic [BW-1:0] bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, pdata_q, pdata_d;
    logic [1:0] samp_q, samp_d;
    logic pen_q, pen_d, ptyp_q, ptyp_d, perr_q, perr_d, serr_q, serr_d;
    logic dv_q, dv_d, pe_q, pe_d, se_q, se_d;
    logic rx_s, vote, last, vote_edge;
    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign half      = ps_q >> 1;
    assign last      = edge_q == ps_q - PRESCALE_W'(1);
    assign vote_edge = edge_q == half + PRESCALE_W'(1);
    // the third sample is the live one, so the vote is ready on edge P/2+1
    assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign bus.P_DATA     = pdata_q;
    assign bus.Data_Valid = dv_q;
    assign bus.Par_Err    = pe_q;
    assign bus.Stp_Err    = se_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sync_q  <= '1;
            edge_q  <= '0;
            bit_q   <= '0;
            ps_q    <= '0;
            shift_q <= '0;
            pdata_q <= '0;
            samp_q  <= '0;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.RX_IN};
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            ps_q    <= ps_d;
            shift_q <= shift_d;
            pdata_q <= pdata_d;
            samp_q  <= samp_d;
            pen_q   <= pen_d;
            ptyp_q  <= ptyp_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            se_q    <= se_d;
        end
    end
    always_comb begin
        state_d = state_q;
        edge_d  = state_q == IDLE ? edge_q : (last ? '0 : edge_q + PRESCALE_W'(1));
        bit_d   = bit_q;
        ps_d    = ps_q;
        shift_d = shift_q;
        pdata_d = pdata_q;
        samp_d  = samp_q;
        pen_d   = pen_q;
        ptyp_d  = ptyp_q;
        perr_d  = perr_q;
        serr_d  = serr_q;
        dv_d    = 1'b0;
        pe_d    = 1'b0;
        se_d    = 1'b0;
        if (state_q != IDLE && edge_q == half - PRESCALE_W'(1)) samp_d[0] = rx_s;
        if (state_q != IDLE && edge_q == half) samp_d[1] = rx_s;
        case (state_q)
            IDLE: if (!rx_s) begin
                state_d = START;
                edge_d  = PRESCALE_W'(1);
                ps_d    = bus.Prescale;
                pen_d   = bus.PAR_EN;
                ptyp_d  = bus.PAR_TYP;
                perr_d  = 1'b0;
                serr_d  = 1'b0;
            end
            START: begin
                if (vote_edge && vote) begin
                    state_d = IDLE;
                    edge_d  = '0;
                end else if (last) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (vote_edge) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
                if (last && bit_q == BW'(DATA_WIDTH - 1)) state_d = pen_q ? PARITY : STOP;
                else if (last) bit_d = bit_q + BW'(1);
            end
            PARITY: begin
                if (vote_edge) perr_d = vote != (^shift_q ^ ptyp_q);
                if (last) state_d = STOP;
            end
            STOP: begin
                if (vote_edge) serr_d = !vote;
                if (last) begin
                    state_d = IDLE;
                    pdata_d = shift_q;
                    pe_d    = perr_q;
                    se_d    = serr_q;
                    dv_d    = !perr_q && !serr_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// tb_uart_rx_frame_receiver: directed and random UART frames checked against a frame-level reference model
module tb_uart_rx_frame_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    typedef struct {
        logic [7:0]  d;
        logic        dv, pe, se;
        int unsigned cyc;
    } rec_t;
    rec_t got[$];
    rec_t exp_q[$];
    uart_rx_frame_receiver_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();
    uart_rx_frame_receiver #(.DATA_WIDTH(8), .PRESCALE_W(6), .SYNC_STAGES(2)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // every cycle with any pulse high is one record, so a stretched pulse shows up as an extra record
    always @(negedge clk)
        if (!rst && (bus.Data_Valid || bus.Par_Err || bus.Stp_Err))
            got.push_back('{bus.P_DATA, bus.Data_Valid, bus.Par_Err, bus.Stp_Err, cyc});
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, req);
        end
    endtask
    task automatic hold(input logic v, input int n);
        bus.RX_IN = v;
        repeat (n) @(posedge clk);
        #1;
    endtask
    // one frame; pe/se/dv and the arrival cycle follow from the frame rules alone
    task automatic send(input logic [7:0] d, input int p, input bit pen, input bit typ,
                        input bit par, input bit stop_v);
        bit pe;
        pe = pen && (par != (^d ^ typ));
        bus.Prescale = 6'(p);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = typ;
        exp_q.push_back('{d, !pe && stop_v, pe, !stop_v, cyc + 32'((10 + int'(pen)) * p + 2)});
        hold(1'b0, 4);
        bus.Prescale = 6'(2 * $urandom_range(3, 31));
        bus.PAR_EN   = 1'($urandom);
        bus.PAR_TYP  = 1'($urandom);
        hold(1'b0, p - 4);
        for (int i = 0; i < 8; i++) hold(d[i], p);
        if (pen) hold(par, p);
        hold(stop_v, p);
    endtask
    task automatic drain(input string tag);
        rec_t r, e;
        chk({tag, ":count"}, got.size(), exp_q.size());
        while (got.size() > 0 && exp_q.size() > 0) begin
            r = got.pop_front();
            e = exp_q.pop_front();
            chk({tag, ":data"}, {24'h0, r.d}, {24'h0, e.d});
            chk({tag, ":valid"}, {31'h0, r.dv}, {31'h0, e.dv});
            chk({tag, ":par_err"}, {31'h0, r.pe}, {31'h0, e.pe});
            chk({tag, ":stp_err"}, {31'h0, r.se}, {31'h0, e.se});
            chk({tag, ":cycle"}, r.cyc, e.cyc);
        end
        got.delete();
        exp_q.delete();
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, ":p_data"}, {24'h0, bus.P_DATA}, 32'h0);
        chk({tag, ":valid"}, {31'h0, bus.Data_Valid}, 32'h0);
        chk({tag, ":par_err"}, {31'h0, bus.Par_Err}, 32'h0);
        chk({tag, ":stp_err"}, {31'h0, bus.Stp_Err}, 32'h0);
    endtask
    initial begin
        logic [7:0] c3;
        int p;
        bus.RX_IN = 1'b1;
        bus.Prescale = 6'd8;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        hold(1'b1, 5);
        send(8'hA5, 8, 1, 0, 0, 1);
        hold(1'b1, 10);
        drain("a5_even");
        send(8'h3C, 16, 1, 1, 0, 1);
        hold(1'b1, 10);
        drain("3c_odd_bad");
        send(8'h81, 8, 0, 0, 0, 0);
        hold(1'b1, 10);
        drain("81_stop0");
        bus.Prescale = 6'd8;
        bus.PAR_EN = 1'b0;
        hold(1'b0, 2);
        hold(1'b1, 20);
        send(8'h5A, 8, 0, 0, 0, 1);
        hold(1'b1, 10);
        drain("glitch_5a");
        send(8'h00, 32, 0, 0, 0, 1);
        send(8'hFF, 32, 0, 0, 0, 1);
        send(8'h55, 32, 0, 0, 0, 1);
        hold(1'b1, 10);
        drain("b2b");
        bus.Prescale = 6'd8;
        bus.PAR_EN = 1'b0;
        exp_q.push_back('{8'h00, 1'b0, 1'b0, 1'b1, cyc + 32'd82});
        exp_q.push_back('{8'h00, 1'b0, 1'b0, 1'b1, cyc + 32'd162});
        exp_q.push_back('{8'hF0, 1'b1, 1'b0, 1'b0, cyc + 32'd242});
        hold(1'b0, 25 * 8);
        hold(1'b1, 5 * 8 + 20);
        drain("break");
        c3 = 8'hC3;
        bus.Prescale = 6'd8;
        bus.PAR_EN = 1'b0;
        hold(1'b0, 8);
        for (int i = 0; i < 4; i++) hold(c3[i], 8);
        hold(c3[4], 3);
        #2 rst = 1'b1;
        #1 chk_zero("mid_reset");
        bus.RX_IN = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        hold(1'b1, 10);
        send(8'h12, 8, 0, 0, 0, 1);
        hold(1'b1, 10);
        drain("after_reset");
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0: p = 8;
                1: p = 16;
                2: p = 32;
                default: p = 2 * int'($urandom_range(3, 31));
            endcase
            begin
                bit pen, typ, par;
                logic [7:0] d;
                d   = 8'($urandom);
                pen = 1'($urandom);
                typ = 1'($urandom);
                par = ($urandom_range(0, 3) == 0) ? !(^d ^ typ) : (^d ^ typ);
                send(d, p, pen, typ, par, $urandom_range(0, 4) != 0);
            end
            if ($urandom_range(0, 2) != 0) hold(1'b1, int'($urandom_range(1, 2)) * p);
        end
        hold(1'b1, 20);
        drain("random");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
